// File: rtl/clb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : clb_pkg
// Description : Shared types and config-field layout helpers for the CLB
//               cluster (state encoding, per-BLE field offsets, chain sizes).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
package clb_pkg;

  // Load state machine encoding
  typedef enum logic [1:0] {
    ST_UNCFG = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2,
    ST_ERROR = 2'd3
  } clb_state_e;

  // Bits in one BLE config field: truth table, three flags, K selectors
  function automatic int ble_bits(input int k, input int sel_w);
    return (1 << k) + 3 + k * sel_w;
  endfunction

  // Total scan-chain length for a cluster of n BLEs
  function automatic int cfg_bits(input int n, input int k, input int sel_w);
    return n * ble_bits(k, sel_w);
  endfunction

  // Offsets inside one BLE field, LSB first
  function automatic int off_truth();
    return 0;
  endfunction

  function automatic int off_reg_sel(input int k);
    return (1 << k);
  endfunction

  function automatic int off_init_val(input int k);
    return (1 << k) + 1;
  endfunction

  function automatic int off_ce_sel(input int k);
    return (1 << k) + 2;
  endfunction

  function automatic int off_sel(input int k, input int sel_w, input int j);
    return (1 << k) + 3 + j * sel_w;
  endfunction

endpackage : clb_pkg
`default_nettype wire

// File: rtl/clb_ble.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : clb_ble
// Description : Basic logic element: K-input LUT, optional flip-flop with
//               config-time init value and selectable clock enable.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module clb_ble #(
  parameter int K = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_en,
  input  logic              ready,
  input  logic              ce,
  input  logic [2**K-1:0]   truth,
  input  logic              reg_sel,
  input  logic              init_val,
  input  logic              ce_sel,
  input  logic [K-1:0]      lin,
  output logic              q,
  output logic              out
);

  logic r_q;
  logic w_lut;

  // LUT lookup: lin[0] is the address LSB
  assign w_lut = truth[lin];

  // FF: reset, then config preload, then hold while not configured, then ce gating
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= 1'b0;
    end else if (cfg_en) begin
      r_q <= init_val;
    end else if (!ready) begin
      r_q <= r_q;
    end else if (ce_sel && !ce) begin
      r_q <= r_q;
    end else begin
      r_q <= w_lut;
    end
  end

  assign q   = r_q;
  assign out = ready ? (reg_sel ? r_q : w_lut) : 1'b0;

endmodule : clb_ble
`default_nettype wire

// File: rtl/clb_cluster.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : clb_cluster
// Description : Configurable logic block cluster: N BLEs with input-select
//               muxes over cluster inputs and local FF feedback, loaded
//               through a daisy-chainable serial scan chain.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module clb_cluster
  import clb_pkg::*;
#(
  parameter int K = 4,
  parameter int N = 4,
  parameter int I = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_en,
  input  logic          cfg_in,
  output logic          cfg_out,
  input  logic          ce,
  input  logic [I-1:0]  in,
  output logic [N-1:0]  out,
  output logic          cfg_done,
  output logic          cfg_err
);

  localparam int SEL_W    = $clog2(I + N);
  localparam int BLE_BITS = ble_bits(K, SEL_W);
  localparam int CFG_BITS = cfg_bits(N, K, SEL_W);
  localparam int CNT_W    = $clog2(CFG_BITS + 1);

  localparam logic [CNT_W-1:0] c_CNT_FULL = CNT_W'(CFG_BITS);
  localparam logic [SEL_W:0]   c_SRC_CNT  = (SEL_W + 1)'(I + N);

  logic [CFG_BITS-1:0] r_chain;
  logic [CNT_W-1:0]    r_cnt;
  clb_state_e          r_state;
  clb_state_e          w_state_nxt;
  logic [N-1:0]        w_q;
  logic [I+N-1:0]      w_src;
  logic                w_ready;

  // Scan chain: new bits enter at the MSB, chain[0] spills to the next cluster
  always_ff @(posedge clk) begin
    if (reset) begin
      r_chain <= '0;
    end else if (cfg_en) begin
      r_chain <= {cfg_in, r_chain[CFG_BITS-1:1]};
    end
  end

  assign cfg_out = r_chain[0];

  // Load counter: restarts at 1 on entry to LOAD, saturates at the chain length
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (cfg_en) begin
      if (r_state != ST_LOAD) begin
        r_cnt <= CNT_W'(1);
      end else if (r_cnt != c_CNT_FULL) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_UNCFG;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: any shift enters LOAD; end of a load checks the bit count
  always_comb begin
    w_state_nxt = r_state;
    if (cfg_en) begin
      w_state_nxt = ST_LOAD;
    end else if (r_state == ST_LOAD) begin
      w_state_nxt = (r_cnt == c_CNT_FULL) ? ST_READY : ST_ERROR;
    end
  end

  assign w_ready  = (r_state == ST_READY);
  assign cfg_done = w_ready;
  assign cfg_err  = (r_state == ST_ERROR);

  // Select sources: cluster inputs first, then registered BLE feedback
  assign w_src = {w_q, in};

  for (genvar b = 0; b < N; b++) begin : g_ble
    localparam int BASE = b * BLE_BITS;

    logic [2**K-1:0] w_truth;
    logic [K-1:0]    w_lin;
    logic            w_init_nxt;

    assign w_truth = r_chain[BASE + off_truth() +: 2**K];

    // The FF preloads from the bit that lands in the init_val slot on this
    // shift, so after the final shift it already holds the final init value.
    assign w_init_nxt = r_chain[BASE + off_ce_sel(K)];

    for (genvar j = 0; j < K; j++) begin : g_sel
      logic [SEL_W-1:0] w_sel;
      assign w_sel    = r_chain[BASE + off_sel(K, SEL_W, j) +: SEL_W];
      assign w_lin[j] = ({1'b0, w_sel} < c_SRC_CNT) ? w_src[w_sel] : 1'b0;
    end

    clb_ble #(
      .K (K)
    ) u_ble (
      .clk      (clk),
      .reset    (reset),
      .cfg_en   (cfg_en),
      .ready    (w_ready),
      .ce       (ce),
      .truth    (w_truth),
      .reg_sel  (r_chain[BASE + off_reg_sel(K)]),
      .init_val (w_init_nxt),
      .ce_sel   (r_chain[BASE + off_ce_sel(K)]),
      .lin      (w_lin),
      .q        (w_q[b]),
      .out      (out[b])
    );
  end

endmodule : clb_cluster
`default_nettype wire

// File: tb/tb_clb_cluster.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : tb_clb_cluster
// Description : Directed self-checking bench for clb_cluster with K=3, I=4,
//               N=2 (SEL_W=3, BLE_BITS=20, CFG_BITS=40).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_clb_cluster;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_en;
  logic       cfg_in;
  logic       cfg_out;
  logic       ce;
  logic [3:0] in;
  logic [1:0] out;
  logic       cfg_done;
  logic       cfg_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [39:0] cfg_a;
  logic [39:0] cfg_b;
  logic [44:0] b45;
  logic [4:0]  prefix;

  clb_cluster #(.K(3), .N(2), .I(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .cfg_en   (cfg_en),
    .cfg_in   (cfg_in),
    .cfg_out  (cfg_out),
    .ce       (ce),
    .in       (in),
    .out      (out),
    .cfg_done (cfg_done),
    .cfg_err  (cfg_err)
  );

  always #5 clk = ~clk;

  // One BLE field: {sel2, sel1, sel0, ce_sel, init_val, reg_sel, truth}
  function automatic logic [19:0] ble_cfg(input logic [7:0] t, input logic rs,
                                          input logic iv, input logic cs,
                                          input logic [2:0] s0, input logic [2:0] s1,
                                          input logic [2:0] s2);
    return {s2, s1, s0, cs, iv, rs, t};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Shift bits[first..last] into the chain, LSB of the word first
  task automatic shift_bits(input logic [39:0] bits, input int first, input int last);
    for (int k = first; k <= last; k++) begin
      cfg_en = 1'b1;
      cfg_in = bits[k];
      step();
    end
  endtask

  // Drop cfg_en and let the FSM evaluate the load
  task automatic finish_load();
    cfg_en = 1'b0;
    cfg_in = 1'b0;
    step();
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    cfg_en = 1'b0;
    cfg_in = 1'b0;
    repeat (2) step();
    reset = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    cfg_en = 1'b0;
    cfg_in = 1'b0;
    ce     = 1'b1;
    in     = 4'b0000;

    // BLE0: 3-input AND, combinational; BLE1: follows in[0], registered, obeys ce
    cfg_a = {ble_cfg(8'hAA, 1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 3'd0),
             ble_cfg(8'h80, 1'b0, 1'b0, 1'b0, 3'd0, 3'd1, 3'd2)};
    // BLE0: registered inverter of its own q; BLE1: combinational copy of q[0]
    cfg_b = {ble_cfg(8'hAA, 1'b0, 1'b0, 1'b0, 3'd4, 3'd0, 3'd0),
             ble_cfg(8'h55, 1'b1, 1'b0, 1'b0, 3'd4, 3'd0, 3'd0)};

    // Reset state
    repeat (3) step();
    check("reset_done", cfg_done, 1'b0);
    check("reset_err",  cfg_err,  1'b0);
    check("reset_out",  out,      2'b00);
    check("reset_cfg_out", cfg_out, 1'b0);
    reset = 1'b0;
    step();
    check("uncfg_idle_err", cfg_err, 1'b0);

    // 1. Full load, combinational AND
    shift_bits(cfg_a, 0, 19);
    in = 4'b0111;
    #1;
    check("load_mid_out", out, 2'b00);
    shift_bits(cfg_a, 20, 39);
    check("load_end_done", cfg_done, 1'b0);
    finish_load();
    check("t1_done", cfg_done, 1'b1);
    check("t1_err",  cfg_err,  1'b0);
    in = 4'b0111;
    #1;
    check("t1_and_0111", out[0], 1'b1);
    in = 4'b0011;
    #1;
    check("t1_and_0011", out[0], 1'b0);
    in = 4'b1110;
    #1;
    check("t1_and_1110", out[0], 1'b0);
    in = 4'b1111;
    #1;
    check("t1_and_1111", out[0], 1'b1);

    // 2. Registered output with clock enable
    in = 4'b0000;
    ce = 1'b1;
    step();
    check("t2_reg_low", out[1], 1'b0);
    in = 4'b0001;
    #1;
    check("t2_reg_not_yet", out[1], 1'b0);
    step();
    check("t2_reg_follow", out[1], 1'b1);
    in = 4'b0000;
    ce = 1'b0;
    step();
    check("t2_ce_hold", out[1], 1'b1);
    ce = 1'b1;
    step();
    check("t2_ce_resume", out[1], 1'b0);

    // 3. Feedback toggle; reconfiguration from READY
    in = 4'b0000;
    shift_bits(cfg_b, 0, 0);
    check("t3_reload_done_drop", cfg_done, 1'b0);
    check("t3_reload_out", out, 2'b00);
    shift_bits(cfg_b, 1, 39);
    finish_load();
    ce = 1'b0;
    check("t3_done", cfg_done, 1'b1);
    check("t3_tog0", out, 2'b00);
    step();
    check("t3_tog1", out, 2'b11);
    step();
    check("t3_tog2", out, 2'b00);
    step();
    check("t3_tog3", out, 2'b11);
    ce = 1'b1;

    // 4. Short load then recovery
    shift_bits(cfg_a, 0, 38);
    finish_load();
    in = 4'b0111;
    #1;
    check("t4_err",  cfg_err,  1'b1);
    check("t4_done", cfg_done, 1'b0);
    check("t4_out",  out,      2'b00);
    shift_bits(cfg_a, 0, 39);
    finish_load();
    check("t4_recover_done", cfg_done, 1'b1);
    check("t4_recover_err",  cfg_err,  1'b0);
    check("t4_recover_and",  out[0],   1'b1);

    // 5. Overlong load: 5 extra leading bits spill out after the reset zeros
    do_reset();
    prefix = 5'b10110;
    b45 = {cfg_a, prefix};
    for (int k = 0; k < 45; k++) begin
      cfg_en = 1'b1;
      cfg_in = b45[k];
      step();
      if (k == 38) check("t5_spill_zero", cfg_out, 1'b0);
      if (k >= 39 && k <= 43) check($sformatf("t5_spill_%0d", k - 39), cfg_out, b45[k - 39]);
    end
    finish_load();
    check("t5_done", cfg_done, 1'b1);
    check("t5_err",  cfg_err,  1'b0);
    in = 4'b0111;
    #1;
    check("t5_and_0111", out[0], 1'b1);
    in = 4'b0011;
    #1;
    check("t5_and_0011", out[0], 1'b0);

    // 6. Reset in the middle of a load (reset wins over cfg_en)
    do_reset();
    shift_bits(cfg_a, 0, 19);
    reset  = 1'b1;
    cfg_en = 1'b1;
    cfg_in = 1'b1;
    step();
    check("t6_done",    cfg_done, 1'b0);
    check("t6_err",     cfg_err,  1'b0);
    check("t6_cfg_out", cfg_out,  1'b0);
    check("t6_out",     out,      2'b00);
    reset = 1'b0;
    finish_load();
    check("t6_idle_err",  cfg_err,  1'b0);
    check("t6_idle_done", cfg_done, 1'b0);
    shift_bits(cfg_a, 0, 38);
    check("t6_partial_done", cfg_done, 1'b0);
    shift_bits(cfg_a, 39, 39);
    finish_load();
    in = 4'b0111;
    #1;
    check("t6_reload_done", cfg_done, 1'b1);
    check("t6_reload_and",  out[0],   1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_clb_cluster
`default_nettype wire

// File: doc/clb_cluster.md
# clb_cluster

- Parametrised configurable logic block cluster: N basic logic elements (BLEs), each a K-input LUT plus an optional flip-flop.
- Every LUT input is chosen from the I cluster inputs and N local feedback outputs.
- Configuration is loaded through a serial scan chain with a load state machine, so clusters daisy-chain into the fabric config path.
- Sits in the FPGA tile between routing switch blocks and the tile output muxes.

## Interface
- K, default 4: LUT inputs per BLE (2..6).
- N, default 4: BLEs per cluster.
- I, default 10: cluster inputs.
- Derived: SEL_W = clog2(I+N); BLE_BITS = 2^K + 3 + K*SEL_W; CFG_BITS = N*BLE_BITS.
- clk  in  1  clock.
- reset  in  1  reset; synchronous, active-high.
- cfg_en  in  1  config shift enable.
- cfg_in  in  1  serial config data in.
- cfg_out  out  1  serial config data out (chain bit 0).
- ce  in  1  cluster clock enable.
- in  in  I  cluster inputs.
- out  out  N  BLE outputs.
- cfg_done  out  1  configuration valid.
- cfg_err  out  1  short load detected.

## Operation
- **Chain shift:** on each clk with cfg_en=1, chain <= {cfg_in, chain[CFG_BITS-1:1]}; cfg_out = chain[0]. The first bit shifted in lands in chain[0] after CFG_BITS shifts.
- **BLE b field:** bits [b*BLE_BITS +: BLE_BITS], laid out LSB first:
  - truth[2^K-1:0]
  - reg_sel: 1 = registered output, 0 = combinational.
  - init_val: FF load value during config.
  - ce_sel: 1 = FF obeys ce, 0 = always enabled.
  - sel[0..K-1], each SEL_W bits.
- **Input select:** sel value v < I picks in[v]; I <= v < I+N picks q[v-I] (registered FF output of BLE v-I); v >= I+N gives 0.
  - Feedback always comes from FF q, never from the LUT, so no combinational loops exist.
- **LUT:** address = {lin[K-1],...,lin[0]}, with lin[0] as the LSB; lut = truth[address].
- **FSM states:** UNCFG, LOAD, READY, ERROR.
  - Reset → UNCFG.
  - Any state with cfg_en=1 → LOAD.
  - LOAD with cfg_en=0 → READY if cnt==CFG_BITS, else ERROR.
- **Counter:** cnt <= 1 on the entering edge into LOAD; +1 per LOAD cycle with cfg_en=1; saturates at CFG_BITS.
  - Extra shifts keep moving the chain and spill out via cfg_out.
  - The cluster is READY only if it holds at least CFG_BITS bits; the last CFG_BITS bits win.
- **Status:** cfg_done = (state==READY); cfg_err = (state==ERROR).
- **FF per BLE, priority order:**
  1. reset → 0
  2. cfg_en → init_val
  3. state!=READY → hold
  4. ce_sel && !ce → hold
  5. otherwise → lut
- **Output:** out[b] = cfg_done ? (reg_sel ? q[b] : lut[b]) : 0.
- **Reset values:** chain all 0, cnt 0, state UNCFG, q 0, out 0, cfg_done 0, cfg_err 0, cfg_out 0.

## Timing
- Combinational BLE: in → out in zero cycles.
- Registered BLE: out updates one edge after inputs are sampled.
- Feedback path: one cycle per hop.
- cfg_done rises on the first edge where cfg_en is sampled 0 with cnt==CFG_BITS. Outputs go live in the cycle after that edge.
- Reconfiguration: cfg_en=1 while READY clears cfg_done at the next edge. out is 0 for the whole load.
- Reset mid-load: everything returns to reset values and the partial chain is discarded. A full reload is required.
- cfg_en and reset asserted together: reset wins.
- A single-cycle cfg_en pulse gives cnt=1, then ERROR (unless CFG_BITS==1).
- ce has no effect on the config chain or the FSM.

## Structure
- **clb_pkg:**
  - FSM state enum (UNCFG/LOAD/READY/ERROR).
  - Field offset functions: truth, reg_sel, init_val, ce_sel, sel[j].
  - BLE_BITS/CFG_BITS helper functions.
- **ble sub-module**, parametrised by K: truth table, reg_sel, init_val and ce_sel config inputs; LUT, FF and output mux.
- **clb_cluster top:** owns the chain, counter, FSM, input-select muxes and N ble instances.

## Test plan
All scenarios use K=3, I=4, N=2, giving SEL_W=3, BLE_BITS=20, CFG_BITS=40.

1. **Full load:** shift 40 bits with BLE0 = AND of in[0..2] (truth=8'h80, combinational, sel=0,1,2).
   - Expect cfg_done=1 one edge after cfg_en drops.
   - in=4'b0111 → out[0]=1; in=4'b0011 → out[0]=0, same cycle.
2. **Registered output:** BLE1 truth=8'hAA (passes lin[0]), reg_sel=1, sel0=0.
   - Toggle in[0] → out[1] follows one cycle later.
   - ce_sel=1 with ce=0 → out[1] holds.
3. **Feedback toggle:** BLE0 sel0=4 (q[0]), truth=8'h55 (inverter), registered.
   - out[0] toggles 0,1,0,1 each cycle after done (init_val=0).
4. **Short load:** shift 39 bits.
   - Expect cfg_err=1, cfg_done=0, out=0.
   - A subsequent 40-bit load → READY and cfg_err=0.
5. **Overlong load:** shift 45 bits.
   - cfg_out replays the first 5 bits shifted in (after the 40 zeros from reset).
   - READY holds the config from the last 40 bits.
6. **Reset during load:** reset at bit 20.
   - Expect state UNCFG, cfg_out=0, out=0.
   - cfg_done stays 0 until a full 40-bit load completes.
